mm_host_sequencer: RTL
======================

// Module: mm_host_sequencer
// PURPOSE
//  Host-side counterpart of the mat_mul_system mailbox. Writes one GEMM command into the scratchpad
//  BRAM (port B), raises start, polls the done word, clears the mailbox, then streams the M*N result
//  words from O_BRAM (port B) out over a valid/ready interface. Sits between the host/DMA command
//  FIFO and the second port of the dual-port SP_BRAM and O_BRAM.
// PARAMETERS
//  DIM_WIDTH     11    width of M, K, N
//  SP_DONE_ADDR  100   byte address of the done word
//  POLL_TIMEOUT  65535 max poll cycles before error; max value 2^20-1 (poll counter is 20 bits)
// PORTS
//  clk                 in   1   clock, all logic on posedge
//  reset_n             in   1   asynchronous, active-low reset
//  cmd_valid           in   1   command present
//  cmd_ready           out  1   command accepted when both high
//  cmd_ws_os           in   1   dataflow select: 0 = WS, 1 = OS
//  cmd_m/cmd_k/cmd_n   in   DIM_WIDTH  matrix dimensions
//  addr_sp_bram_b      out  32  SP byte address
//  enable_sp_bram_b    out  1   SP port enable
//  w_enable_sp_bram_b  out  4   SP byte write enables
//  data_in_sp_bram_b   out  32  SP write data
//  data_out_sp_bram_b  in   32  SP read data, valid 1 cycle after an enabled read
//  addr_o_bram_b       out  32  O byte address
//  enable_o_bram_b     out  1   O read enable
//  data_out_o_bram_b   in   32  O read data, 1-cycle latency
//  res_valid/res_ready out/in 1 result handshake
//  res_data            out  32  result word, row-major: C[0][0], C[0][1], ...
//  res_last            out  1   high with the final word (index M*N-1)
//  busy                out  1   high in any state except IDLE/ERROR
//  done                out  1   one-cycle pulse after the last result handshake
//  err                 out  1   sticky; cleared only by reset
// BEHAVIOUR
//  Reset: every output is 0 and the FSM is in IDLE. Reset mid-operation aborts immediately and
//   mailbox contents are not restored.
//  Port B writes: enable=1, w_enable=4'b1111, one word per cycle. Port B reads: enable=1, w_enable=0.
//  When enable is 0, addr, w_enable and data_in are also driven 0.
//  IDLE: cmd_ready=1. Handshake latches the command. If M, K or N is 0 -> ERROR; no SP access occurs.
//  CFG (5 cycles, starting the cycle after the handshake):
//   addr4 <- {31'b0,ws_os}, addr8 <- M, addr12 <- K, addr16 <- N, SP_DONE_ADDR <- 0.
//  START (1 cycle): addr0 <- 1. Start is always the final write, so the config is complete first.
//  POLL: read SP_DONE_ADDR every cycle. Each read's data is checked on the following cycle.
//   data==1 -> CLEAR. The poll counter increments per cycle; at POLL_TIMEOUT -> ERROR.
//  CLEAR (2 cycles): addr0 <- 0, then SP_DONE_ADDR <- 0.
//  RD_ISSUE: O read at addr 4*idx, idx from 0. RD_WAIT: capture data_out_o_bram_b into res_data and
//   set res_valid. HOLD: res_data, res_valid and res_last stay stable until res_ready.
//   On handshake: if idx==M*N-1 -> FINISH, else idx+1 -> RD_ISSUE.
//   Throughput is 1 word per 3 cycles when res_ready is held high.
//  FINISH: done=1 for one cycle -> IDLE.
//  ERROR: err=1, all BRAM enables 0, cmd_ready=0. Exit is by reset only.
//  idx and the M*N product are 2*DIM_WIDTH bits; addr = {idx,2'b00} zero-extended to 32 bits.
//  A cmd_valid that arrives while busy is ignored (cmd_ready=0); the command is not lost upstream.
//  A done word already equal to 1 before START cannot be seen, because CFG clears it.
//  res_ready high before res_valid has no effect.
// STRUCTURE
//  Shared package mm_mailbox_pkg: SP_START_ADDR=0, SP_WSOS_ADDR=4, SP_M_ADDR=8, SP_K_ADDR=12,
//   SP_N_ADDR=16, SP_DONE_ADDR=100, WS=0/OS=1, BRAM_WE_ALL=4'b1111. The accelerator side imports the same package.
//  One sub-module, mm_result_streamer: the RD_ISSUE/RD_WAIT/HOLD loop and the idx counter.
//   Ports: start, total, O port, res_*, finished.
//  The top level owns the mailbox FSM and the poll/timeout counter.
// TESTING  (bench: mm_host_sequencer + dual-port BRAM models + mat_mul_system, 1-cycle latency)
//  1. Cmd OS, M=6,K=5,N=4, A[i][k]=10(i+1)+(k+1), W[k][j]=10(k+1)+(j+1) -> SP writes in order 4,8,12,16,
//     100,0 with data 1,6,5,4,0,1; 24 results, each equal to the dot product;
//     res_last only on word 23; one done pulse.
//  2. Same command with WS (ws_os=0), M=N=K=8, all-ones data -> 64 words, each =8; SP addr0 and addr100
//     read back as 0 after done.
//  3. Scenario 1 with res_ready toggling 1/0 every cycle -> no word lost or duplicated; res_data stable
//     while res_valid=1 and res_ready=0.
//  4. cmd_k=0 -> err=1 the next cycle, enable_sp_bram_b never asserted, cmd_ready stays 0.
//  5. POLL_TIMEOUT=50 with a stalled accelerator model -> err rises exactly 50 cycles after POLL is
//     entered; all enables 0.
//  6. reset_n low during POLL -> all outputs 0 asynchronously; after release, a new command runs to
//     completion.

Source files
------------

// File: rtl/mm_mailbox_pkg.sv
// Mailbox layout shared by the host sequencer and the mat_mul_system accelerator.
package mm_mailbox_pkg;

    localparam logic [31:0] SP_START_ADDR = 32'd0;
    localparam logic [31:0] SP_WSOS_ADDR  = 32'd4;
    localparam logic [31:0] SP_M_ADDR     = 32'd8;
    localparam logic [31:0] SP_K_ADDR     = 32'd12;
    localparam logic [31:0] SP_N_ADDR     = 32'd16;
    localparam logic [31:0] SP_DONE_ADDR  = 32'd100;

    localparam logic       WS          = 1'b0;
    localparam logic       OS          = 1'b1;
    localparam logic [3:0] BRAM_WE_ALL = 4'b1111;

    localparam logic [31:0] MBOX_GO   = 32'd1;
    localparam logic [31:0] MBOX_CLR  = 32'd0;
    localparam logic [31:0] DONE_FLAG = 32'd1;

    typedef enum logic [2:0] {
        H_IDLE, H_CFG, H_START, H_POLL, H_CLEAR, H_STREAM, H_FINISH, H_ERROR
    } host_state_e;

    typedef enum logic [1:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_HOLD
    } strm_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sp_write_t;

    // Mailbox write sequence: steps 0..4 are configuration, step 5 is the start word.
    function automatic sp_write_t cfg_write(input logic [2:0]  step,
                                            input logic [31:0] ws_os_w,
                                            input logic [31:0] m_w,
                                            input logic [31:0] k_w,
                                            input logic [31:0] n_w,
                                            input logic [31:0] done_addr);
        sp_write_t w;
        case (step)
            3'd0:    w = '{addr: SP_WSOS_ADDR,  data: ws_os_w};
            3'd1:    w = '{addr: SP_M_ADDR,     data: m_w};
            3'd2:    w = '{addr: SP_K_ADDR,     data: k_w};
            3'd3:    w = '{addr: SP_N_ADDR,     data: n_w};
            3'd4:    w = '{addr: done_addr,     data: MBOX_CLR};
            3'd5:    w = '{addr: SP_START_ADDR, data: MBOX_GO};
            default: w = '{addr: 32'd0,         data: 32'd0};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mm_result_streamer.sv
// Reads M*N result words from O_BRAM port B and presents them on a valid/ready stream.
module mm_result_streamer
    import mm_mailbox_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 22
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [IDX_WIDTH-1:0] total,
    output logic [31:0]          addr_o_bram_b,
    output logic                 enable_o_bram_b,
    input  logic [31:0]          data_out_o_bram_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic                 res_last,
    output logic                 finished
);

    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

    strm_state_e          state_r;
    logic [IDX_WIDTH-1:0] idx_r;
    logic [IDX_WIDTH-1:0] idx_next_s;
    logic                 is_last_s;
    logic [31:0]          o_addr_r;
    logic                 o_en_r;
    logic [31:0]          res_data_r;
    logic                 res_valid_r;
    logic                 res_last_r;
    logic                 finished_r;

    // Next index and last-word detection for the word currently being fetched.
    always_comb begin
        idx_next_s = idx_r + IDX_ONE;
        is_last_s  = (idx_r == (total - IDX_ONE));
    end

    // Issue / wait / hold loop; every output is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            idx_r       <= '0;
            o_addr_r    <= 32'd0;
            o_en_r      <= 1'b0;
            res_data_r  <= 32'd0;
            res_valid_r <= 1'b0;
            res_last_r  <= 1'b0;
            finished_r  <= 1'b0;
        end else begin
            finished_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r  <= S_ISSUE;
                        idx_r    <= '0;
                        o_en_r   <= 1'b1;
                        o_addr_r <= 32'd0;
                    end else begin
                        o_en_r   <= 1'b0;
                        o_addr_r <= 32'd0;
                    end
                end
                S_ISSUE: begin
                    state_r  <= S_WAIT;
                    o_en_r   <= 1'b0;
                    o_addr_r <= 32'd0;
                end
                S_WAIT: begin
                    state_r     <= S_HOLD;
                    res_data_r  <= data_out_o_bram_b;
                    res_valid_r <= 1'b1;
                    res_last_r  <= is_last_s;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        res_last_r  <= 1'b0;
                        res_data_r  <= 32'd0;
                        if (res_last_r) begin
                            finished_r <= 1'b1;
                            state_r    <= S_IDLE;
                        end else begin
                            idx_r    <= idx_next_s;
                            o_en_r   <= 1'b1;
                            o_addr_r <= 32'({idx_next_s, 2'b00});
                            state_r  <= S_ISSUE;
                        end
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    o_en_r      <= 1'b0;
                    o_addr_r    <= 32'd0;
                    res_valid_r <= 1'b0;
                    res_last_r  <= 1'b0;
                    res_data_r  <= 32'd0;
                end
            endcase
        end
    end

    assign addr_o_bram_b   = o_addr_r;
    assign enable_o_bram_b = o_en_r;
    assign res_data        = res_data_r;
    assign res_valid       = res_valid_r;
    assign res_last        = res_last_r;
    assign finished        = finished_r;

endmodule

// File: rtl/mm_host_sequencer.sv
// Host-side mailbox driver for mat_mul_system: configure, start, poll, clear, stream results.
module mm_host_sequencer
    import mm_mailbox_pkg::*;
#(
    parameter int unsigned DIM_WIDTH    = 11,
    parameter int unsigned SP_DONE_ADDR = 100,
    parameter int unsigned POLL_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_ws_os,
    input  logic [DIM_WIDTH-1:0] cmd_m,
    input  logic [DIM_WIDTH-1:0] cmd_k,
    input  logic [DIM_WIDTH-1:0] cmd_n,
    output logic [31:0]          addr_sp_bram_b,
    output logic                 enable_sp_bram_b,
    output logic [3:0]           w_enable_sp_bram_b,
    output logic [31:0]          data_in_sp_bram_b,
    input  logic [31:0]          data_out_sp_bram_b,
    output logic [31:0]          addr_o_bram_b,
    output logic                 enable_o_bram_b,
    input  logic [31:0]          data_out_o_bram_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic                 res_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned PW        = 2 * DIM_WIDTH;
    localparam logic [31:0] DONE_ADDR = 32'(SP_DONE_ADDR);
    localparam logic [19:0] POLL_LAST = 20'(POLL_TIMEOUT - 1);

    host_state_e          state_r;
    logic [2:0]           step_r;
    logic [19:0]          poll_cnt_r;
    logic                 poll_chk_r;
    logic                 ws_os_r;
    logic [DIM_WIDTH-1:0] m_r;
    logic [DIM_WIDTH-1:0] k_r;
    logic [DIM_WIDTH-1:0] n_r;
    logic                 cmd_ready_r;
    logic [31:0]          sp_addr_r;
    logic                 sp_en_r;
    logic [3:0]           sp_we_r;
    logic [31:0]          sp_wdata_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic                 strm_start_r;
    logic                 strm_finished_s;
    logic                 dims_zero_s;
    logic [PW-1:0]        total_s;
    sp_write_t            cfg_w_s;

    // Next mailbox write: step 0 comes straight from the command bus, later steps from latched dims.
    always_comb begin
        dims_zero_s = (cmd_m == '0) || (cmd_k == '0) || (cmd_n == '0);
        total_s     = PW'(m_r) * PW'(n_r);
        if (state_r == H_IDLE) begin
            cfg_w_s = cfg_write(3'd0, {31'd0, cmd_ws_os}, 32'(cmd_m), 32'(cmd_k),
                                32'(cmd_n), DONE_ADDR);
        end else begin
            cfg_w_s = cfg_write(step_r + 3'd1, {31'd0, ws_os_r}, 32'(m_r), 32'(k_r),
                                32'(n_r), DONE_ADDR);
        end
    end

    // Mailbox FSM with the poll/timeout counter; SP port and status outputs are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= H_IDLE;
            step_r       <= 3'd0;
            poll_cnt_r   <= 20'd0;
            poll_chk_r   <= 1'b0;
            ws_os_r      <= 1'b0;
            m_r          <= '0;
            k_r          <= '0;
            n_r          <= '0;
            cmd_ready_r  <= 1'b0;
            sp_addr_r    <= 32'd0;
            sp_en_r      <= 1'b0;
            sp_we_r      <= 4'd0;
            sp_wdata_r   <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            strm_start_r <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            strm_start_r <= 1'b0;
            case (state_r)
                H_IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        ws_os_r     <= cmd_ws_os;
                        m_r         <= cmd_m;
                        k_r         <= cmd_k;
                        n_r         <= cmd_n;
                        if (dims_zero_s) begin
                            state_r <= H_ERROR;
                            err_r   <= 1'b1;
                        end else begin
                            state_r    <= H_CFG;
                            busy_r     <= 1'b1;
                            step_r     <= 3'd0;
                            sp_en_r    <= 1'b1;
                            sp_we_r    <= BRAM_WE_ALL;
                            sp_addr_r  <= cfg_w_s.addr;
                            sp_wdata_r <= cfg_w_s.data;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                H_CFG: begin
                    // Step 4 is the last config write; the next one is the start word.
                    state_r    <= (step_r == 3'd4) ? H_START : H_CFG;
                    step_r     <= step_r + 3'd1;
                    sp_addr_r  <= cfg_w_s.addr;
                    sp_wdata_r <= cfg_w_s.data;
                end
                H_START: begin
                    state_r    <= H_POLL;
                    poll_cnt_r <= 20'd0;
                    poll_chk_r <= 1'b0;
                    sp_we_r    <= 4'd0;
                    sp_addr_r  <= DONE_ADDR;
                    sp_wdata_r <= 32'd0;
                end
                H_POLL: begin
                    poll_chk_r <= 1'b1;
                    poll_cnt_r <= poll_cnt_r + 20'd1;
                    if (poll_chk_r && (data_out_sp_bram_b == DONE_FLAG)) begin
                        state_r    <= H_CLEAR;
                        step_r     <= 3'd0;
                        sp_we_r    <= BRAM_WE_ALL;
                        sp_addr_r  <= SP_START_ADDR;
                        sp_wdata_r <= MBOX_CLR;
                    end else if (poll_cnt_r == POLL_LAST) begin
                        state_r    <= H_ERROR;
                        err_r      <= 1'b1;
                        busy_r     <= 1'b0;
                        sp_en_r    <= 1'b0;
                        sp_we_r    <= 4'd0;
                        sp_addr_r  <= 32'd0;
                        sp_wdata_r <= 32'd0;
                    end else begin
                        state_r <= H_POLL;
                    end
                end
                H_CLEAR: begin
                    if (step_r == 3'd0) begin
                        step_r     <= 3'd1;
                        sp_addr_r  <= DONE_ADDR;
                        sp_wdata_r <= MBOX_CLR;
                    end else begin
                        state_r      <= H_STREAM;
                        strm_start_r <= 1'b1;
                        sp_en_r      <= 1'b0;
                        sp_we_r      <= 4'd0;
                        sp_addr_r    <= 32'd0;
                        sp_wdata_r   <= 32'd0;
                    end
                end
                H_STREAM: begin
                    if (strm_finished_s) begin
                        state_r <= H_FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= H_STREAM;
                    end
                end
                H_FINISH: begin
                    state_r     <= H_IDLE;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                H_ERROR: begin
                    // Sticky until reset: no port activity, no new commands.
                    err_r       <= 1'b1;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    sp_en_r     <= 1'b0;
                    sp_we_r     <= 4'd0;
                    sp_addr_r   <= 32'd0;
                    sp_wdata_r  <= 32'd0;
                end
                default: begin
                    state_r     <= H_ERROR;
                    err_r       <= 1'b1;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    sp_en_r     <= 1'b0;
                    sp_we_r     <= 4'd0;
                    sp_addr_r   <= 32'd0;
                    sp_wdata_r  <= 32'd0;
                end
            endcase
        end
    end

    mm_result_streamer #(
        .IDX_WIDTH(PW)
    ) u_streamer (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (strm_start_r),
        .total             (total_s),
        .addr_o_bram_b     (addr_o_bram_b),
        .enable_o_bram_b   (enable_o_bram_b),
        .data_out_o_bram_b (data_out_o_bram_b),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .res_last          (res_last),
        .finished          (strm_finished_s)
    );

    assign cmd_ready          = cmd_ready_r;
    assign addr_sp_bram_b     = sp_addr_r;
    assign enable_sp_bram_b   = sp_en_r;
    assign w_enable_sp_bram_b = sp_we_r;
    assign data_in_sp_bram_b  = sp_wdata_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign err                = err_r;

endmodule
